top_fpga: RTL and testbench
===========================

TOP_FPGA -- requirements
Module: top_fpga

Interface
REQ-001 The block SHALL have one parameter: TICK_DIV, default 25000000, the number of clock cycles per pattern tick; legal values are integers of 2 or more.
REQ-002 The block SHALL have one clock and an asynchronous active-low reset.
REQ-003 Port IO_CLK_P, input, 1 bit: positive leg of the single differential board clock; all logic is clocked on its rising edge.
REQ-004 Port IO_CLK_N, input, 1 bit: negative leg of the same clock, always the complement of IO_CLK_P; no logic is clocked from it.
REQ-005 Port IO_RST_N, input, 1 bit: asynchronous active-low reset.
REQ-006 Port LED, output, 4 bits: board LEDs; LED[0] is the heartbeat and LED[3:1] is the sweep pattern.

Function
REQ-007 The clock SHALL be recovered from IO_CLK_P/IO_CLK_N through a differential input buffer, or a functionally equivalent model that uses IO_CLK_P directly.
REQ-008 A 2-flop synchronizer SHALL generate the internal reset rst_n:
- rst_n asserts asynchronously when IO_RST_N falls;
- rst_n deasserts on the 2nd rising clock edge after IO_RST_N goes high.
REQ-009 All registers SHALL reset asynchronously on rst_n.
REQ-010 The prescaler SHALL be a counter of width $clog2(TICK_DIV):
- it resets to 0;
- it increments on each edge;
- on the edge where it equals TICK_DIV-1 it wraps to 0 and the advance strobe is active in that cycle.
REQ-011 LED[0] SHALL toggle on every advance edge and hold otherwise.
REQ-012 LED[3:1] SHALL follow a 4-state sweep FSM that advances only on advance edges:
- S0 drives 001, next S1;
- S1 drives 010, next S2;
- S2 drives 100, next S3;
- S3 drives 010, next S0.
REQ-013 The full LED sequence SHALL be 0010 -> 0101 -> 1000 -> 0101 -> 0010, with a period of 4*TICK_DIV cycles.
REQ-014 LED SHALL be driven directly from registers, with no combinational path from any input to LED.
REQ-015 The first LED change after reset release SHALL occur on the TICK_DIV-th rising edge after rst_n deasserts.
REQ-016 Any values of TICK_DIV below 2 SHALL be rejected at elaboration by an assertion or $error.
REQ-017 The LED value SHALL change only on advance edges; between ticks it is held stable.

Reset
REQ-018 While rst_n is low, LED SHALL equal 4'b0010, the FSM SHALL be in S0 and the prescaler SHALL be 0.
REQ-019 A reset asserted mid-operation SHALL force LED to 0010 within the same cycle, without waiting for a clock edge.
REQ-020 After a mid-operation reset, counting SHALL restart from 0; no partial tick is retained.
REQ-021 A reset pulse shorter than one clock period SHALL still reset all state.
REQ-022 Release of the internal reset SHALL be synchronous: IO_RST_N released between edges takes effect on the 2nd following rising edge.

Verification (bench uses TICK_DIV=4)
REQ-023 Hold IO_RST_N=0 for 20 cycles -> LED=0010 throughout, with no X values after the first cycle.
REQ-024 Release IO_RST_N, then run 4 edges after rst_n deasserts -> LED changes to 0101 on the 4th edge.
REQ-025 Run 16 cycles after the first change -> LED steps through 1000, 0101, 0010, 0101, each held exactly 4 cycles.
REQ-026 Pull IO_RST_N low while LED=1000 -> LED=0010 immediately; after release, the next change occurs 4 edges after rst_n deasserts.
REQ-027 Pulse IO_RST_N low for 0.3 cycle between edges -> LED returns to 0010 and the prescaler returns to 0.
REQ-028 Hold IO_RST_N low, then raise it mid-cycle -> rst_n is still low after the 1st edge and goes high at the 2nd edge.

Source files
------------

// File: rtl/top_fpga.sv
`default_nettype none
// ============================================================================
//  Module   : top_fpga
//  Brief    : LED heartbeat and 3-LED sweep pattern driven by a prescaled
//             tick, with a 2-flop reset synchronizer on the board reset.
//  Revision : 1.0  initial release
// ============================================================================
module top_fpga #(
    parameter int TICK_DIV = 25000000
) (
    input  logic       IO_CLK_P,
    input  logic       IO_CLK_N,
    input  logic       IO_RST_N,
    output logic [3:0] LED
);

    // Counter width; guarded so an illegal TICK_DIV still elaborates far
    // enough to reach the parameter check below.
    localparam int c_cnt_w = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TICK_DIV - 1);

    // Sweep FSM state encoding
    localparam logic [1:0] c_s0 = 2'd0;
    localparam logic [1:0] c_s1 = 2'd1;
    localparam logic [1:0] c_s2 = 2'd2;
    localparam logic [1:0] c_s3 = 2'd3;

    if (TICK_DIV < 2) begin : g_tick_div_check
        $error("top_fpga: TICK_DIV must be 2 or more");
    end

    logic               clk;
    logic               rst_n;
    logic               w_unused_clk_n;
    logic [1:0]         r_rst_sync;
    logic [c_cnt_w-1:0] r_cnt;
    logic               w_adv;
    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [2:0]         w_pat_nxt;
    logic [2:0]         r_pat;
    logic               r_hb;

    // Functional model of the differential input buffer: the positive leg
    // carries the clock; the negative leg is only its complement.
    assign clk            = IO_CLK_P;
    assign w_unused_clk_n = IO_CLK_N;

    // Reset synchronizer: asserts asynchronously, releases on the 2nd edge
    always_ff @(posedge clk or negedge IO_RST_N) begin
        if (!IO_RST_N) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign rst_n = r_rst_sync[1];

    // Prescaler: counts 0..TICK_DIV-1; the terminal count is the advance cycle
    assign w_adv = (r_cnt == c_cnt_last);

    // Prescaler counter with wrap on the advance cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_adv) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_cnt_w'(1);
        end
    end

    // Next sweep state and the pattern that state will drive
    always_comb begin
        w_state_nxt = c_s0;
        w_pat_nxt   = 3'b001;
        case (r_state)
            c_s0: begin w_state_nxt = c_s1; w_pat_nxt = 3'b010; end
            c_s1: begin w_state_nxt = c_s2; w_pat_nxt = 3'b100; end
            c_s2: begin w_state_nxt = c_s3; w_pat_nxt = 3'b010; end
            c_s3: begin w_state_nxt = c_s0; w_pat_nxt = 3'b001; end
            default: begin w_state_nxt = c_s0; w_pat_nxt = 3'b001; end
        endcase
    end

    // FSM, registered pattern and heartbeat; all update only on advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_s0;
            r_pat   <= 3'b001;
            r_hb    <= 1'b0;
        end else if (w_adv) begin
            r_state <= w_state_nxt;
            r_pat   <= w_pat_nxt;
            r_hb    <= ~r_hb;
        end
    end

    // LEDs come straight from flops: no input-to-output combinational path
    assign LED = {r_pat, r_hb};

endmodule
`default_nettype wire

// File: tb/tb_top_fpga.sv
`default_nettype none
// ============================================================================
//  Module   : tb_top_fpga
//  Brief    : Directed scoreboard bench for top_fpga with TICK_DIV = 4.
//  Revision : 1.0  initial release
// ============================================================================
module tb_top_fpga;

    localparam int TICK = 4;

    logic       clk_p;
    logic       clk_n;
    logic       rst_in_n;
    logic [3:0] led;

    int errors = 0;
    int checks = 0;

    logic [3:0] sb[$];
    logic [3:0] pat_tbl[4];

    top_fpga #(.TICK_DIV(TICK)) dut (
        .IO_CLK_P (clk_p),
        .IO_CLK_N (clk_n),
        .IO_RST_N (rst_in_n),
        .LED      (led)
    );

    initial begin
        clk_p = 1'b0;
        forever #5 clk_p = ~clk_p;
    end
    assign clk_n = ~clk_p;

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "bench timeout");
    end

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Expected LED for the k-th edge after the internal reset releases
    task automatic push_seq(input int k_from, input int k_to);
        for (int k = k_from; k <= k_to; k++) begin
            sb.push_back(pat_tbl[(k / TICK) % 4]);
        end
    endtask

    task automatic push_const(input int n, input logic [3:0] v);
        for (int i = 0; i < n; i++) sb.push_back(v);
    endtask

    task automatic run_check(input int n, input string tag);
        logic [3:0] exp;
        for (int i = 0; i < n; i++) begin
            @(posedge clk_p);
            #1;
            if (sb.size() == 0) begin
                errors++;
                checks++;
                $display("FAIL %s: observed=empty-queue expected=entry", tag);
            end else begin
                exp = sb.pop_front();
                chk(tag, led, exp);
            end
        end
    endtask

    initial begin
        pat_tbl[0] = 4'b0010;
        pat_tbl[1] = 4'b0101;
        pat_tbl[2] = 4'b1000;
        pat_tbl[3] = 4'b0101;

        // Reset held for 20 cycles
        rst_in_n = 1'b0;
        push_const(20, 4'b0010);
        run_check(20, "reset_hold");
        chk("rst_n_low", {3'b000, dut.rst_n}, 4'b0000);

        // Release mid-cycle; rst_n rises on the 2nd edge
        #3 rst_in_n = 1'b1;
        @(posedge clk_p); #1;
        chk("sync_edge1", {3'b000, dut.rst_n}, 4'b0000);
        @(posedge clk_p); #1;
        chk("sync_edge2", {3'b000, dut.rst_n}, 4'b0001);

        // Full sweep, ending while LED = 1000
        push_seq(1, 25);
        run_check(25, "sweep");

        // Mid-operation reset acts without a clock edge
        #2 rst_in_n = 1'b0;
        #1;
        chk("midrun_async_led", led, 4'b0010);
        chk("midrun_rst_n", {3'b000, dut.rst_n}, 4'b0000);
        push_const(3, 4'b0010);
        run_check(3, "midrun_hold");

        // Release and restart counting from zero
        #3 rst_in_n = 1'b1;
        @(posedge clk_p); #1;
        chk("resync_edge1", {3'b000, dut.rst_n}, 4'b0000);
        @(posedge clk_p); #1;
        chk("resync_edge2", {3'b000, dut.rst_n}, 4'b0001);
        push_seq(1, 6);
        run_check(6, "restart");
        chk("cnt_before_pulse", {2'b00, dut.r_cnt}, 4'(6 % TICK));

        // Short reset pulse between edges
        #2 rst_in_n = 1'b0;
        #3 rst_in_n = 1'b1;
        #0;
        chk("pulse_led", led, 4'b0010);
        chk("pulse_cnt", {2'b00, dut.r_cnt}, 4'b0000);
        chk("pulse_rst_n", {3'b000, dut.rst_n}, 4'b0000);
        @(posedge clk_p); #1;
        chk("pulse_edge1", {3'b000, dut.rst_n}, 4'b0000);
        @(posedge clk_p); #1;
        chk("pulse_edge2", {3'b000, dut.rst_n}, 4'b0001);
        push_seq(1, 8);
        run_check(8, "after_pulse");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
